// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command stream to APB initiator bridge
//
// Purpose: accepts one write/read command at a time from a host-side valid/ready
// stream, runs it as an APB SETUP/ACCESS transfer, and returns read data and
// status on a valid/ready response channel that is held until consumed.
//
// Ports:
//   p_clk_i, p_rst_i                    clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o             command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i      command: 1=write, byte address, write data
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_dat_o, rsp_err_o                read data (0 for writes), timeout flag
//   p_sel_o, p_enable_o, p_we_o         APB control
//   p_adr_o, p_dat_o                    APB address / write data (hold when idle)
//   p_dat_i, p_ready_i                  APB read data / ready from responder
//
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase that sees
// no p_ready_i for TIMEOUT_CYCLES cycles; the abort returns rsp_err_o=1, data 0.
// Without the macro the master waits forever and rsp_err_o stays 0.

module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              p_clk_i,
  input  logic              p_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_adr_o,
  output logic [DATA_W-1:0] p_dat_o,
  input  logic [DATA_W-1:0] p_dat_i,
  input  logic              p_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic we_q;         // direction of the transfer in flight
  logic cmd_fire;     // command handshake this cycle
  logic access_ok;    // ACCESS completes with p_ready_i this cycle
  logic timeout_hit;  // ACCESS is abandoned this cycle

  // Reset gates the ready so nothing is accepted while reset is asserted.
  // A pending response must be consumed (or consumed this cycle) before a new
  // command goes out, which keeps exactly one transfer outstanding.
  assign cmd_ready_o = p_rst_i && (state == ST_IDLE) && (!rsp_valid_o || rsp_ready_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

`ifdef APB_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles that ended without p_ready_i. The abort fires on the
  // last allowed ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYCLES cycles.
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      wait_cnt <= '0;
    end else if (cmd_fire) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !p_ready_i) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == ST_ACCESS) && !p_ready_i &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (p_ready_i || timeout_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus outputs decoded from state; p_we_o is forced low on an idle bus.
  always_comb begin
    p_sel_o    = 1'b0;
    p_enable_o = 1'b0;
    p_we_o     = 1'b0;
    access_ok  = 1'b0;
    case (state)
      ST_SETUP: begin
        p_sel_o = 1'b1;
        p_we_o  = we_q;
      end
      ST_ACCESS: begin
        p_sel_o    = 1'b1;
        p_enable_o = 1'b1;
        p_we_o     = we_q;
        access_ok  = p_ready_i;
      end
      default: begin
      end
    endcase
  end

  // Command capture; address and write data keep their last value when idle.
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      we_q    <= 1'b0;
      p_adr_o <= '0;
      p_dat_o <= '0;
    end else if (cmd_fire) begin
      we_q    <= cmd_we_i;
      p_adr_o <= cmd_adr_i;
      p_dat_o <= cmd_dat_i;
    end
  end

  // Response channel. Loading a new response and consuming the old one can
  // never coincide, because a new command waits for the old response.
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else if (access_ok) begin
      rsp_valid_o <= 1'b1;
      rsp_dat_o   <= we_q ? '0 : p_dat_i;
      rsp_err_o   <= 1'b0;
    end else if (timeout_hit) begin
      rsp_valid_o <= 1'b1;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b1;
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end
  end

endmodule
